// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants: bus widths, reset/enable levels, FSM encodings.
// No logic of its own; pc_inc is the sequential-fetch increment.
// Imported by the interface, the IF/ID register and the fetch stage.
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam logic  RST_ENABLE  = 1'b1;
  localparam logic  CHIP_ENABLE = 1'b1;
  localparam inst_t ZERO_WORD   = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_HOLD  = 2'b10
  } if_state_t;

  // Word-sequential next address; wraps 32'hFFFF_FFFC to 0 naturally.
  function automatic inst_addr_t pc_inc(input inst_addr_t pc);
    return pc + inst_addr_t'(4);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: ROM request/ack, decode-side control and the IF/ID outputs.
// master is the fetch stage; slave is the ROM plus decode side.
// Flow control is the ROM ack and the decode stall carried here.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       rom_ce;
  inst_addr_t rom_addr;
  logic       rom_ack;
  inst_t      rom_data;

  logic       stall;
  logic       branch_flag;
  inst_addr_t branch_target;

  inst_addr_t id_pc;
  inst_t      id_inst;
  logic       id_valid;

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_valid,
    input  rom_ack, rom_data, stall, branch_flag, branch_target
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid,
    output rom_ack, rom_data, stall, branch_flag, branch_target
  );

endinterface

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: captures a delivered {pc, inst} or inserts a NOP bubble.
// Latency: 1 cycle from load to outputs.
// Backpressure: stall freezes the register; load is never asserted while stalled.
module if_id
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       load,
  input  inst_addr_t src_pc,
  input  inst_t      src_inst,
  output inst_addr_t id_pc,
  output inst_t      id_inst,
  output logic       id_valid
);

  // Load on delivery, bubble when decode is free with nothing new, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      id_pc    <= '0;
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
    end else if (load) begin
      id_pc    <= src_pc;
      id_inst  <= src_inst;
      id_valid <= 1'b1;
    end else if (!stall) begin
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, requests the ROM, buffers data across decode stalls.
// Latency: 1 cycle ack-to-decode; zero-wait ROM sustains 1 instruction/cycle.
// Backpressure: an acked word under stall parks in the hold buffer and the ROM is idled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  if_state_t  state;
  inst_addr_t pc;
  inst_addr_t hold_pc;
  inst_t      hold_inst;
  logic       redir_pend;
  inst_addr_t redir_target;
  logic       rom_ce;
  inst_addr_t rom_addr;

  logic       deliver;
  inst_addr_t src_pc;
  inst_t      src_inst;
  inst_addr_t next_pc;

  assign bus.rom_ce   = rom_ce;
  assign bus.rom_addr = rom_addr;

  // Pick the delivery source and the address after it; a pulse in the delivery
  // cycle overrides any older pending target, since the newest branch wins.
  always_comb begin
    deliver  = 1'b0;
    src_pc   = pc;
    src_inst = bus.rom_data;
    case (state)
      IF_FETCH: deliver = bus.rom_ack && !bus.stall;
      IF_HOLD: begin
        deliver  = !bus.stall;
        src_pc   = hold_pc;
        src_inst = hold_inst;
      end
      default: deliver = 1'b0;
    endcase
    if (bus.branch_flag)
      next_pc = bus.branch_target;
    else if (redir_pend)
      next_pc = redir_target;
    else
      next_pc = pc_inc(pc);
  end

  // Fetch FSM with registered ROM request; the PC only advances on delivery,
  // so the delivered instruction is always the delay slot of any earlier pulse.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state        <= IF_IDLE;
      pc           <= RESET_PC;
      hold_pc      <= '0;
      hold_inst    <= ZERO_WORD;
      redir_pend   <= 1'b0;
      redir_target <= '0;
      rom_ce       <= ~CHIP_ENABLE;
      rom_addr     <= '0;
    end else begin
      if (deliver) begin
        redir_pend <= 1'b0;
      end else if (bus.branch_flag) begin
        redir_pend   <= 1'b1;
        redir_target <= bus.branch_target;
      end
      case (state)
        IF_IDLE: begin
          state    <= IF_FETCH;
          rom_ce   <= CHIP_ENABLE;
          rom_addr <= pc;
        end
        IF_FETCH: begin
          if (bus.rom_ack) begin
            if (!bus.stall) begin
              pc       <= next_pc;
              rom_addr <= next_pc;
            end else begin
              hold_pc   <= pc;
              hold_inst <= bus.rom_data;
              rom_ce    <= ~CHIP_ENABLE;
              state     <= IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!bus.stall) begin
            pc       <= next_pc;
            rom_addr <= next_pc;
            rom_ce   <= CHIP_ENABLE;
            state    <= IF_FETCH;
          end
        end
        default: begin
          state  <= IF_IDLE;
          rom_ce <= ~CHIP_ENABLE;
        end
      endcase
    end
  end

  if_id u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall),
    .load     (deliver),
    .src_pc   (src_pc),
    .src_inst (src_inst),
    .id_pc    (bus.id_pc),
    .id_inst  (bus.id_inst),
    .id_valid (bus.id_valid)
  );

endmodule
